// File: rtl/spi_slave_responder.sv
// SPI target responder: synchronises sclk/ss_n/mosi into clk, shifts MSB-first frames in and out in any CPOL/CPHA mode.
// rx_valid follows the sampling sclk edge by SYNC_STAGES+2 clk at most; there is no backpressure, tx_hold is simply overwritten.
module spi_slave_responder #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_TX     = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_empty,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_abort,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                   lead_edge, trail_edge;
  logic                   sample_edge, shift_edge;
  logic                   frame_start, last_bit;
  logic                   cpol_r, cpha_r;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       tx_sh, rx_sh, tx_hold, reload_word, rx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  // Mode is taken from the copy latched at frame start, never the live pins.
  assign lead_edge   = cpol_r ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_r ? sclk_rise : sclk_fall;
  assign sample_edge = busy & ~ss_rise & (cpha_r ? trail_edge : lead_edge);
  assign shift_edge  = busy & ~ss_rise & (cpha_r ? lead_edge : trail_edge);
  assign frame_start = (state == IDLE) & ss_fall;
  assign last_bit    = sample_edge & (cnt == CW'(WIDTH - 1));
  assign reload_word = tx_empty ? IDLE_TX : tx_hold;
  assign rx_next     = {rx_sh[WIDTH-2:0], mosi_s};

  assign busy    = (state == ACTIVE);
  assign miso_oe = busy & ~ss_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx_sh[MSB] is always the next bit to present; cpha=0 presents the MSB at
  // frame start, so its first shift edge must move on to bit WIDTH-2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      tx_empty <= 1'b1;
      tx_hold  <= IDLE_TX;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cnt      <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;

      if (tx_load) tx_hold <= tx_data;

      if (tx_load)                      tx_empty <= 1'b0;
      else if (frame_start || last_bit) tx_empty <= 1'b1;

      if (frame_start) begin
        cpol_r <= cpol;
        cpha_r <= cpha;
        cnt    <= '0;
        miso   <= reload_word[WIDTH-1];
        tx_sh  <= cpha ? reload_word : {reload_word[WIDTH-2:0], 1'b0};
      end

      if (shift_edge) begin
        miso  <= tx_sh[WIDTH-1];
        tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
      end

      if (sample_edge) begin
        rx_sh <= rx_next;
        if (last_bit) begin
          cnt      <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          tx_sh    <= reload_word;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      if (busy && ss_rise) begin
        cnt <= '0;
        if (cnt != '0) rx_abort <= 1'b1;
      end
    end
  end

endmodule
